// File: rtl/rgb_axis_s2mm_packer.sv
// Purpose : packs camera RGB pixels into 32-bit AXI4-Stream beats for the S2MM DMA.
// Latency : 2 pixclk from a pixel on the input pins to tvalid, when the FIFO is empty.
// Backpressure: a FIFO_DEPTH-beat FIFO absorbs tready=0; pushes into a full FIFO are dropped and counted.
//
// Ports
//   pixclk, reset        : single rising-edge clock, asynchronous active-low reset
//   enable               : arms capture; low forces IDLE and clears overflow/drop_count
//   fval, valid          : camera frame-valid and pixel qualifier
//   iRed/iGreen/iBlue    : pixel channels
//   m_axis_s2mm_*        : AXI4-Stream master (tdata = {8'h00,R,G,B}, tuser = SOF, tlast = EOL)
//   overflow, drop_count : sticky overflow flag and saturating count of dropped pixels
//   frame_done           : 1-cycle pulse after the last beat of a frame is accepted
//
// Optional build macro RGB_PACK_TEST_PATTERN_EN replaces the camera data with a
// col/row test pattern (R=col, G=row, B=col^row); timing still follows valid/fval.

// Generic show-ahead FIFO.
// Latency : a write appears on rd_dat/rd_vld the cycle after it is accepted.
// Backpressure: wr_rdy drops when full, except when a read frees a slot in the same cycle.
module fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  input  logic             rd_rdy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign rd_vld = (count != '0);
  // A simultaneous pop makes room, so a full FIFO still accepts that write.
  assign wr_rdy = (count != FULL_CNT) || rd_rdy;
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_vld && rd_rdy;
  assign rd_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_dat;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (!push && pop) begin
        count <= count - 1'b1;
      end
    end
  end
endmodule

module rgb_axis_s2mm_packer #(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  pixclk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fval,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] iRed,
  input  logic [DATA_WIDTH-1:0] iGreen,
  input  logic [DATA_WIDTH-1:0] iBlue,
  input  logic                  m_axis_s2mm_tready,
  output logic                  m_axis_s2mm_tvalid,
  output logic [31:0]           m_axis_s2mm_tdata,
  output logic                  m_axis_s2mm_tuser,
  output logic                  m_axis_s2mm_tlast,
  output logic                  overflow,
  output logic [15:0]           drop_count,
  output logic                  frame_done
);
  localparam int COL_W  = $clog2(IMG_WIDTH);
  localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int ENTRY_W = 35;  // {tag, tuser, tlast, tdata[31:0]}

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_WAIT_SOF = 2'd1;
  localparam logic [1:0] ST_ACTIVE   = 2'd2;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

  logic [1:0]            state;
  logic                  fval_r;
  logic                  fval_r2;
  logic                  valid_r;
  logic [DATA_WIDTH-1:0] red_r;
  logic [DATA_WIDTH-1:0] green_r;
  logic [DATA_WIDTH-1:0] blue_r;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row;

  logic                  fval_rise;
  logic                  fval_fall;
  logic                  col_last;
  logic                  row_last;
  logic                  push_req;
  logic                  frame_end;
  logic                  drop;
  logic [DATA_WIDTH-1:0] px_r;
  logic [DATA_WIDTH-1:0] px_g;
  logic [DATA_WIDTH-1:0] px_b;
  logic [31:0]           beat_dat;
  logic [ENTRY_W-1:0]    fifo_wr_dat;
  logic                  fifo_wr_rdy;
  logic                  fifo_rd_vld;
  logic [ENTRY_W-1:0]    fifo_rd_dat;
  logic                  pop;

  // Input stage: every camera signal is registered once, so the FSM, the
  // counters and the push all work on the same aligned copy.
  // fval history resets high so that a frame already running when reset
  // releases is not mistaken for a fresh start of frame.
  always_ff @(posedge pixclk or negedge reset) begin
    if (!reset) begin
      fval_r  <= 1'b1;
      fval_r2 <= 1'b1;
      valid_r <= 1'b0;
      red_r   <= '0;
      green_r <= '0;
      blue_r  <= '0;
    end else begin
      fval_r  <= fval;
      fval_r2 <= fval_r;
      valid_r <= valid;
      red_r   <= iRed;
      green_r <= iGreen;
      blue_r  <= iBlue;
    end
  end

  assign fval_rise = fval_r && !fval_r2;
  assign fval_fall = !fval_r && fval_r2;
  assign col_last  = (col == COL_LAST);
  assign row_last  = (row == ROW_LAST);
  assign push_req  = (state == ST_ACTIVE) && valid_r;
  assign frame_end = push_req && col_last && row_last;

  // Frame FSM and pixel position. Dropped pixels still advance col/row so
  // the markers on later beats stay aligned with the image.
  always_ff @(posedge pixclk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      col   <= '0;
      row   <= '0;
    end else if (!enable) begin
      state <= ST_IDLE;
      col   <= '0;
      row   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_WAIT_SOF;
        end
        ST_WAIT_SOF: begin
          if (fval_rise) begin
            state <= ST_ACTIVE;
          end
        end
        ST_ACTIVE: begin
          if (valid_r) begin
            if (col_last) begin
              col <= '0;
              if (row_last) begin
                row   <= '0;
                state <= ST_WAIT_SOF;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
          // Short frame: abandon the partial frame and wait for the next SOF.
          if (fval_fall && !frame_end) begin
            state <= ST_WAIT_SOF;
            col   <= '0;
            row   <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          col   <= '0;
          row   <= '0;
        end
      endcase
    end
  end

`ifdef RGB_PACK_TEST_PATTERN_EN
  logic [31:0] col_ext;
  logic [31:0] row_ext;
  assign col_ext = 32'(col);
  assign row_ext = 32'(row);
  assign px_r    = col_ext[DATA_WIDTH-1:0];
  assign px_g    = row_ext[DATA_WIDTH-1:0];
  assign px_b    = col_ext[DATA_WIDTH-1:0] ^ row_ext[DATA_WIDTH-1:0];
`else
  assign px_r = red_r;
  assign px_g = green_r;
  assign px_b = blue_r;
`endif

  assign beat_dat = 32'({px_r, px_g, px_b});
  // The tag marks the final pixel of the frame so frame_done can fire when
  // that exact beat leaves, however long it sat in the FIFO.
  assign fifo_wr_dat = {frame_end, (col == '0) && (row == '0), col_last, beat_dat};

  fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (pixclk),
    .rst_n  (reset),
    .wr_vld (push_req),
    .wr_dat (fifo_wr_dat),
    .wr_rdy (fifo_wr_rdy),
    .rd_vld (fifo_rd_vld),
    .rd_dat (fifo_rd_dat),
    .rd_rdy (m_axis_s2mm_tready)
  );

  assign drop = push_req && !fifo_wr_rdy;
  assign pop  = fifo_rd_vld && m_axis_s2mm_tready;

  // Payload is forced to zero while nothing is queued so the bus reads as
  // idle after reset instead of exposing stale memory contents.
  assign m_axis_s2mm_tvalid = fifo_rd_vld;
  assign m_axis_s2mm_tdata  = fifo_rd_vld ? fifo_rd_dat[31:0] : 32'd0;
  assign m_axis_s2mm_tlast  = fifo_rd_vld && fifo_rd_dat[32];
  assign m_axis_s2mm_tuser  = fifo_rd_vld && fifo_rd_dat[33];

  always_ff @(posedge pixclk or negedge reset) begin
    if (!reset) begin
      overflow   <= 1'b0;
      drop_count <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= pop && fifo_rd_dat[34];
      if (!enable) begin
        overflow   <= 1'b0;
        drop_count <= '0;
      end else if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_rgb_axis_s2mm_packer.sv
// Bench for rgb_axis_s2mm_packer: 4x2 image, 16-beat FIFO, reference queue model.
module tb_rgb_axis_s2mm_packer;
  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 16;

  logic        pixclk = 1'b0;
  logic        reset;
  logic        enable;
  logic        fval;
  logic        valid;
  logic [7:0]  iRed;
  logic [7:0]  iGreen;
  logic [7:0]  iBlue;
  logic        tready;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tuser;
  logic        tlast;
  logic        overflow;
  logic [15:0] drop_count;
  logic        frame_done;

  rgb_axis_s2mm_packer #(
    .DATA_WIDTH (8),
    .IMG_WIDTH  (W),
    .IMG_HEIGHT (H),
    .FIFO_DEPTH (D)
  ) dut (
    .pixclk             (pixclk),
    .reset              (reset),
    .enable             (enable),
    .fval               (fval),
    .valid              (valid),
    .iRed               (iRed),
    .iGreen             (iGreen),
    .iBlue              (iBlue),
    .m_axis_s2mm_tready (tready),
    .m_axis_s2mm_tvalid (tvalid),
    .m_axis_s2mm_tdata  (tdata),
    .m_axis_s2mm_tuser  (tuser),
    .m_axis_s2mm_tlast  (tlast),
    .overflow           (overflow),
    .drop_count         (drop_count),
    .frame_done         (frame_done)
  );

  always #5 pixclk = ~pixclk;

  typedef struct packed {
    logic [31:0] dat;
    logic        user;
    logic        last;
    logic        done;
  } beat_t;

  // Reference: expected beats in delivery order, plus the one pixel that is
  // in flight between the input pins and the FIFO.
  beat_t q[$];
  beat_t stg;
  beat_t drv;
  bit    stg_vld;
  bit    drv_vld;
  bit    exp_ovf;
  bit    exp_done;
  int    exp_drop;
  int    px_idx;
  int    done_seen;
  int    beats_seen;
  int    n_cmp;
  int    n_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model
  // across the rising edge using the inputs that the DUT sampled there.
  task automatic tick();
    bit pop;
    bit drop;
    @(negedge pixclk);
    chk("tvalid", 32'(tvalid), 32'(q.size() > 0));
    if (q.size() > 0) begin
      chk("tdata", tdata, q[0].dat);
      chk("tuser", 32'(tuser), 32'(q[0].user));
      chk("tlast", 32'(tlast), 32'(q[0].last));
    end
    chk("frame_done", 32'(frame_done), 32'(exp_done));
    chk("overflow", 32'(overflow), 32'(exp_ovf));
    chk("drop_count", 32'(drop_count), 32'(exp_drop));
    if (frame_done === 1'b1) done_seen++;
    if (tvalid === 1'b1 && tready === 1'b1) beats_seen++;
    pop  = (q.size() > 0) && (tready === 1'b1);
    drop = stg_vld && (q.size() == D) && !pop;
    @(posedge pixclk);
    exp_done = pop && q[0].done;
    if (pop) void'(q.pop_front());
    if (stg_vld && !drop) q.push_back(stg);
    if (!enable) begin
      exp_ovf  = 1'b0;
      exp_drop = 0;
    end else if (drop) begin
      exp_ovf = 1'b1;
      if (exp_drop < 65535) exp_drop++;
    end
    stg     = drv;
    stg_vld = drv_vld;
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one pixel; cap says whether a capture is armed for this frame.
  task automatic send_px(input bit cap, input logic [7:0] rr, input logic [7:0] gg,
                         input logic [7:0] bb);
    int c;
    int r;
    c = px_idx % W;
    r = (px_idx / W) % H;
    valid  = 1'b1;
    iRed   = rr;
    iGreen = gg;
    iBlue  = bb;
`ifdef RGB_PACK_TEST_PATTERN_EN
    drv.dat = {8'h00, 8'(c), 8'(r), 8'(c) ^ 8'(r)};
`else
    drv.dat = {8'h00, rr, gg, bb};
`endif
    drv.user = (px_idx == 0);
    drv.last = (c == W - 1);
    drv.done = (px_idx == W * H - 1);
    drv_vld  = cap;
    px_idx++;
    tick();
    valid   = 1'b0;
    drv_vld = 1'b0;
  endtask

  // mode 0: random data; mode 1: R=G=B=pixel index. rnd: random tready and gaps.
  task automatic frame(input int npix, input bit cap, input int mode, input bit rnd);
    logic [7:0] v;
    fval = 1'b0;
    ticks(3);
    fval = 1'b1;
    ticks(3);
    px_idx = 0;
    for (int i = 0; i < npix; i++) begin
      if (rnd) tready = 1'($urandom_range(0, 1));
      if (mode == 1) begin
        v = 8'(i);
        send_px(cap, v, v, v);
      end else begin
        send_px(cap, 8'($urandom), 8'($urandom), 8'($urandom));
      end
      if (rnd) ticks($urandom_range(0, 1));
    end
    fval = 1'b0;
  endtask

  initial begin
    n_cmp = 0;      n_err = 0;
    stg = '0;       drv = '0;
    stg_vld = 1'b0; drv_vld = 1'b0;
    exp_ovf = 1'b0; exp_done = 1'b0; exp_drop = 0;
    px_idx = 0;     done_seen = 0;  beats_seen = 0;
    reset = 1'b0;   enable = 1'b0;  fval = 1'b0;  valid = 1'b0;
    iRed = 8'h00;   iGreen = 8'h00; iBlue = 8'h00; tready = 1'b1;

    // Reset values.
    #1;
    chk("rst_tvalid", 32'(tvalid), 32'd0);
    chk("rst_tdata", tdata, 32'd0);
    chk("rst_tuser", 32'(tuser), 32'd0);
    chk("rst_tlast", 32'(tlast), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    ticks(3);
    reset = 1'b1;

    // Disabled: pixels and frames produce nothing.
    frame(6, 1'b0, 0, 1'b0);
    ticks(4);

    // Directed frame, R=G=B=n, tready held high.
    enable = 1'b1;
    tready = 1'b1;
    done_seen = 0;
    frame(W * H, 1'b1, 1, 1'b0);
    ticks(8);
    chk("done_pulses_frame", 32'(done_seen), 32'd1);

    // Overflow: 20 pixels into a stalled 16-deep FIFO, then drain.
    tready = 1'b0;
    frame(W * H, 1'b1, 0, 1'b0);
    frame(W * H, 1'b1, 0, 1'b0);
    frame(4, 1'b1, 0, 1'b0);
    ticks(2);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop_count", 32'(drop_count), 32'd4);
    beats_seen = 0;
    done_seen  = 0;
    tready = 1'b1;
    ticks(24);
    chk("drained_beats", 32'(beats_seen), 32'd16);
    chk("drained_done_pulses", 32'(done_seen), 32'd2);
    enable = 1'b0;
    ticks(2);
    chk("ovf_cleared", 32'(overflow), 32'd0);

    // fval already high when capture is armed: that frame is skipped.
    fval = 1'b1;
    ticks(3);
    enable = 1'b1;
    ticks(3);
    px_idx = 0;
    for (int i = 0; i < 3; i++) send_px(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    ticks(3);
    frame(W * H, 1'b1, 0, 1'b1);
    tready = 1'b1;
    ticks(8);

    // Random frames with random backpressure, including a short frame.
    for (int k = 0; k < 6; k++) begin
      frame((k == 2) ? 5 : W * H, 1'b1, 0, 1'b1);
    end
    tready = 1'b1;
    ticks(24);

    // Asynchronous reset with beats queued and tready low.
    tready = 1'b0;
    fval = 1'b0;
    ticks(3);
    fval = 1'b1;
    ticks(3);
    px_idx = 0;
    for (int i = 0; i < 5; i++) send_px(1'b1, 8'($urandom), 8'($urandom), 8'($urandom));
    ticks(2);
    chk("queued_before_reset", 32'(tvalid), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_tvalid", 32'(tvalid), 32'd0);
    chk("async_rst_tdata", tdata, 32'd0);
    q.delete();
    stg_vld = 1'b0;
    exp_ovf = 1'b0;
    exp_drop = 0;
    exp_done = 1'b0;
    ticks(2);
    reset = 1'b1;
    tready = 1'b1;
    // Mid-frame pixels after reset must not be captured.
    for (int i = 0; i < 3; i++) send_px(1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
    ticks(10);
    fval = 1'b0;
    ticks(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
